// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one request at a time to an 8-bit ALU unit bank
// and returns the selected unit's 16-bit result over a valid/ready channel.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake; req_op, req_a, req_b payload
//   opnd_a, opnd_b              registered operands fanned out to all units
//   unit_start                  one-hot, one-cycle start pulse
//   unit_res, unit_done         per-unit results (16 bits each) and done strobes
//   rsp_valid/rsp_ready         response handshake; rsp_res, rsp_op, rsp_err
//   busy                        high whenever the sequencer is not idle
//   op_count                    completed responses, wraps at 16 bits
//
// Build option: define ALU_SEQ_TIMEOUT_EN to add a WAIT watchdog that gives
// up after TIMEOUT cycles and answers with rsp_err = 1, rsp_res = 0xDEAD.

module alu_op_sequencer #(
    parameter int                   NUM_UNITS      = 6,
    parameter int                   OPW            = 3,
    parameter logic [NUM_UNITS-1:0] FIXED_LAT_MASK = 6'b000111,
    parameter int                   TIMEOUT        = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [OPW-1:0]          req_op,
    input  logic [7:0]              req_a,
    input  logic [7:0]              req_b,
    output logic [7:0]              opnd_a,
    output logic [7:0]              opnd_b,
    output logic [NUM_UNITS-1:0]    unit_start,
    input  logic [16*NUM_UNITS-1:0] unit_res,
    input  logic [NUM_UNITS-1:0]    unit_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_res,
    output logic [OPW-1:0]          rsp_op,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [15:0]             op_count
);

    // Elaboration-time sanity check of the configuration.
    if ((2 ** OPW) < NUM_UNITS || TIMEOUT < 1) begin : g_bad_cfg
        $error("alu_op_sequencer: invalid OPW/NUM_UNITS/TIMEOUT");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [OPW:0] NU_W = (OPW+1)'(NUM_UNITS);

    state_t state;

    logic        op_ok;
    logic [15:0] sel_res;
    logic        sel_done;
    logic        sel_fixed;

    assign op_ok = ({1'b0, req_op} < NU_W);

    // rsp_op doubles as the latched op code for the whole transaction,
    // so the result slice and done bit are selected from it.
    always_comb begin
        sel_res   = '0;
        sel_done  = 1'b0;
        sel_fixed = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (rsp_op == OPW'(i)) begin
                sel_res   = unit_res[16*i +: 16];
                sel_done  = unit_done[i];
                sel_fixed = FIXED_LAT_MASK[i];
            end
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            opnd_a     <= '0;
            opnd_b     <= '0;
            unit_start <= '0;
            rsp_valid  <= 1'b0;
            rsp_res    <= '0;
            rsp_op     <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        opnd_a    <= req_a;
                        opnd_b    <= req_b;
                        rsp_op    <= req_op;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        if (op_ok) begin
                            unit_start <= NUM_UNITS'(1) << req_op;
                            state      <= ISSUE;
                        end else begin
                            // No unit behind this code: answer at once.
                            rsp_err   <= 1'b1;
                            rsp_res   <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    unit_start <= '0;
                    state      <= WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
                    wait_cnt   <= '0;
`endif
                end
                WAIT: begin
                    // Fixed-latency units registered res on the ISSUE edge,
                    // so the first WAIT cycle already sees it.
                    if (sel_fixed || sel_done) begin
                        rsp_res   <= sel_res;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
`ifdef ALU_SEQ_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        rsp_res   <= 16'hDEAD;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks of alu_op_sequencer
// against unit models and a reference result/latency model in the bench.

module tb_alu_op_sequencer;

    localparam int NU  = 6;
    localparam int OPW = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [7:0]  req_a = '0;
    logic [7:0]  req_b = '0;
    logic [7:0]  opnd_a;
    logic [7:0]  opnd_b;
    logic [5:0]  unit_start;
    logic [95:0] unit_res;
    logic [5:0]  unit_done;
    logic [5:0]  model_done;
    logic [5:0]  spur_done = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_res;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        busy;
    logic [15:0] op_count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .NUM_UNITS(NU),
        .OPW(OPW),
        .FIXED_LAT_MASK(6'b000111),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_a(req_a),
        .req_b(req_b),
        .opnd_a(opnd_a),
        .opnd_b(opnd_b),
        .unit_start(unit_start),
        .unit_res(unit_res),
        .unit_done(unit_done),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_res(rsp_res),
        .rsp_op(rsp_op),
        .rsp_err(rsp_err),
        .busy(busy),
        .op_count(op_count)
    );

    // Reference arithmetic: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 MUL, 5 DIV/MOD.
    function automatic logic [15:0] ref_fn(input int op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            0: return {8'h00, a & b};
            1: return {8'h00, a | b};
            2: return {8'h00, a ^ b};
            3: return 16'(a) + 16'(b);
            4: return 16'(a) * 16'(b);
            5: return (b == 8'h00) ? 16'hFFFF : {a % b, a / b};
            default: return 16'h0000;
        endcase
    endfunction

    // Done delay after start for each unit; 0 means no done is ever sent.
    int          dly [NU];
    int          dcnt [NU];
    logic [15:0] ures [NU];

    always @(posedge clk) begin
        for (int i = 0; i < NU; i++) begin
            if (unit_start[i]) begin
                ures[i] <= ref_fn(i, opnd_a, opnd_b);
                dcnt[i] <= dly[i];
            end else if (dcnt[i] != 0) begin
                dcnt[i] <= dcnt[i] - 1;
            end
        end
    end

    always_comb begin
        unit_res   = '0;
        model_done = '0;
        for (int i = 0; i < NU; i++) begin
            unit_res[16*i +: 16] = ures[i];
            model_done[i]        = (dcnt[i] == 1);
        end
    end

    assign unit_done = model_done | spur_done;

    int         start_pulses = 0;
    logic [5:0] last_start = '0;

    always @(negedge clk) begin
        if (unit_start != 6'd0) begin
            start_pulses <= start_pulses + 1;
            last_start   <= unit_start;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int op);
        if (op >= NU) return 1;
        if (op < 3) return 3;
        return 2 + dly[op];
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int hold,
                          input int exp_lat, input logic [15:0] exp_res,
                          input logic exp_err);
        int   p0;
        int   lat;
        logic got;
        @(negedge clk);
        p0 = start_pulses;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = (hold == 0);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                lat = k;
            end else begin
                chk("busy_wait", 32'(busy), 32'd1);
                spur_done = 6'($urandom) & ~(6'd1 << op);
            end
        end
        spur_done = '0;
        chk("latency", lat, exp_lat);
        chk("rsp_res", 32'(rsp_res), 32'(exp_res));
        chk("rsp_op", 32'(rsp_op), 32'(op));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("opnd_a", 32'(opnd_a), 32'(a));
        chk("opnd_b", 32'(opnd_b), 32'(b));
        chk("start_pulses", start_pulses - p0, (int'(op) < NU) ? 1 : 0);
        if (int'(op) < NU)
            chk("start_onehot", 32'(last_start), 32'(6'd1 << op));
        // Response back-pressure: a competing request must not get in.
        if (hold > 0) begin
            req_valid = 1'b1;
            req_op    = 3'($urandom);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_res", 32'(rsp_res), 32'(exp_res));
                chk("hold_op", 32'(rsp_op), 32'(op));
                chk("hold_req_ready", 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        exp_cnt = exp_cnt + 16'd1;
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_err", 32'(rsp_err), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [2:0] rop;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       seen;
        dly = '{0, 0, 0, 2, 7, 4};

        // Reset state.
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(unit_start), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operations.
        run_op(3'd1, 8'h5A, 8'h0F, 0, 3, 16'h005F, 1'b0);
        run_op(3'd4, 8'hFF, 8'hFF, 0, 9, 16'hFE01, 1'b0);
        run_op(3'd7, 8'h12, 8'h34, 0, 1, 16'h0000, 1'b1);
        run_op(3'd2, 8'h3C, 8'hA5, 5, 3, 16'h0099, 1'b0);
        run_op(3'd5, 8'd100, 8'd7, 1, 6, 16'h020E, 1'b0);

        // Asynchronous reset in the middle of a mul wait.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_a     = 8'h21;
        req_b     = 8'h43;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_start", 32'(unit_start), 32'd0);
        chk("arst_opnd", 32'({opnd_a, opnd_b}), 32'd0);
        chk("arst_rsp", 32'({rsp_valid, rsp_err, rsp_res, rsp_op}), 32'd0);
        chk("arst_op_count", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | rsp_valid | busy;
        end
        rsp_ready = 1'b0;
        chk("arst_no_rsp", 32'(seen), 32'd0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            run_op(rop, ra, rb, $urandom_range(0, 2), lat_of(int'(rop)),
                   ref_fn(int'(rop), ra, rb), (int'(rop) >= NU));
        end

`ifdef ALU_SEQ_TIMEOUT_EN
        // Done never arrives: 8 WAIT cycles then the error answer.
        dly[5] = 0;
        run_op(3'd5, 8'd50, 8'd5, 0, 10, 16'hDEAD, 1'b1);
        // Done on the last WAIT cycle wins over the watchdog.
        dly[5] = 8;
        run_op(3'd5, 8'd50, 8'd5, 0, 10, ref_fn(5, 8'd50, 8'd5), 1'b0);
        // Done one cycle too late: timeout, and the late strobe is ignored.
        dly[5] = 9;
        run_op(3'd5, 8'd9, 8'd2, 0, 10, 16'hDEAD, 1'b1);
        dly[5] = 4;
        run_op(3'd3, 8'hF0, 8'h20, 0, 4, 16'h0110, 1'b0);
`endif

        // op_count wrap from 0xFFFF.
        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.op_count;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        chk("preset_op_count", 32'(op_count), 32'hFFFF);
        run_op(3'd0, 8'hC3, 8'h5F, 0, 3, 16'h0043, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Central controller for the 8-bit ALU unit bank (logic, add/sub, mul, div units, each with `clk`/`a`/`b`/`start`/16-bit `res`).
- Accepts one operation request at a time over a valid/ready handshake.
- Holds the operands stable and pulses `start` to the selected unit for one cycle.
- Waits for the unit's result: a fixed 1-cycle latency for registered logic units, or a `done` strobe for multi-cycle units.
- Returns the 16-bit result over a valid/ready response channel.

Parameters:
- `NUM_UNITS`, 6, number of attached ALU units; op codes `0..NUM_UNITS-1` are valid.
- `OPW`, 3, op-code width; requires `2**OPW >= NUM_UNITS`.
- `FIXED_LAT_MASK`, 6'b000111, bit i = 1: unit i registers `res` on the edge after `start` and has no `done`; bit i = 0: unit i signals completion with `unit_done[i]`.
- `TIMEOUT`, 255, watchdog limit in WAIT cycles; used only with the optional feature.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_op`  in  OPW  unit select.
- `req_a`  in  8  operand A.
- `req_b`  in  8  operand B.
- `opnd_a`  out  8  registered operand A, fanned out to all units.
- `opnd_b`  out  8  registered operand B, fanned out to all units.
- `unit_start`  out  NUM_UNITS  one-hot start pulse.
- `unit_res`  in  16*NUM_UNITS  concatenated unit results; unit i occupies bits [16i+15:16i].
- `unit_done`  in  NUM_UNITS  completion strobes; ignored for fixed-latency units.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_res`  out  16  result.
- `rsp_op`  out  OPW  op code of this response.
- `rsp_err`  out  1  invalid op, or timeout (optional feature).
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  16  count of completed responses.

Behaviour:
- **Reset** (`rst_n` low, asynchronous; takes effect mid-operation too): state = IDLE and every output = 0 except `req_ready` = 1. In-flight operations are dropped with no response. Release is synchronous to `clk`.
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid` && `req_ready`: latch `req_a`/`req_b` into `opnd_a`/`opnd_b`, latch `req_op`.
  - If `req_op >= NUM_UNITS`: go to RESP with `rsp_err` = 1 and `rsp_res` = 0.
  - Otherwise go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `unit_start[op]` = 1; all other `unit_start` bits = 0.
  - Next state is WAIT.
- **WAIT**
  - `unit_start` = 0.
  - Fixed-latency unit: capture `unit_res` slice op in the first WAIT cycle, then go to RESP.
  - Done-based unit: stay in WAIT until `unit_done[op]` = 1, capture the slice in that same cycle, then go to RESP. `unit_done` asserted in the ISSUE cycle is ignored.
  - `unit_done` bits for non-selected units are ignored.
- **RESP**
  - `rsp_valid` = 1; `rsp_res`, `rsp_op` and `rsp_err` hold stable until the handshake.
  - On `rsp_ready`: `op_count` += 1 (wraps 0xFFFF → 0), clear `rsp_valid` and `rsp_err`, return to IDLE.
  - A new request is not accepted in the same cycle; `req_ready` = 0 in RESP.
- **Latency:** accept at edge T → `unit_start` high during cycle T+1 → fixed-latency `rsp_valid` high from edge T+3. Done-based units add the `done` wait. Invalid op: `rsp_valid` high from edge T+1.
- `opnd_a`/`opnd_b` change only on request acceptance and stay stable through ISSUE, WAIT and RESP.
- **Throughput:** fixed-latency back-to-back is one op per 4 cycles when `rsp_ready` is held high.

Optional Feature:
- Macro: `ALU_SEQ_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit-or-wider counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without the awaited `unit_done`: go to RESP with `rsp_err` = 1 and `rsp_res` = 0xDEAD.
  - A `done` strobe arriving afterwards is ignored.
  - `unit_done` coinciding with the counter reaching `TIMEOUT`: `done` wins, no error.
- **Not defined:** no counter; WAIT on a done-based unit is unbounded.

Test Plan:
1. Reset mid-WAIT on op 4 → all outputs 0, `req_ready` = 1 immediately (asynchronous), no response produced.
2. op = 1 (OR unit), a = 0x5A, b = 0x0F, `rsp_ready` = 1 → `unit_start` = 6'b000010 for exactly one cycle; `rsp_res` = 0x005F and `rsp_op` = 1 with `rsp_valid` 3 cycles after accept; `op_count` = 1.
3. op = 4 (mul model, `done` 7 cycles after `start`), a = 0xFF, b = 0xFF → `rsp_res` = 0xFE01; `busy` stays high throughout; a spurious `unit_done[3]` during the wait is ignored.
4. op = 7 (invalid) → no `unit_start` pulse; `rsp_valid` at T+1 with `rsp_err` = 1, `rsp_res` = 0x0000.
5. op = 2 with `rsp_ready` low for 5 cycles → `rsp_res`/`rsp_op` stable and `req_ready` = 0 throughout; a new request waits; `op_count` increments once.
6. `ALU_SEQ_TIMEOUT_EN` defined, `TIMEOUT` = 8, op = 5 whose `done` never arrives → `rsp_err` = 1, `rsp_res` = 0xDEAD after 8 WAIT cycles. Also preset `op_count` to 0xFFFF via 65535 ops (or force) → next response wraps it to 0.
